// File: rtl/pipelined_rca_pkg.sv
// Shared parameter helpers for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Valid/ready bus for the pipelined adder: input beat side plus result side.
interface pipelined_rca_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_rca_slice.sv
// Combinational SW-bit ripple-carry chain; also exposes the carry into its MSB.
module rca_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);
  logic [SW:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[SW];
  assign c_msb = c[SW-1];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one SW-bit slice resolved per stage,
// whole-pipeline stall on backpressure.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipelined_rca_if.slave bus
);
  localparam int SW = slice_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_rca: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic             en;
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [SW-1:0]    sl_sum  [STAGES];
  logic             sl_cout [STAGES];
  logic             sl_cmsb [STAGES];

  assign en = ~v_q[STAGES-1] | bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction is folded into the input: a + ~b + ~cin.
      assign src_v[k] = bus.in_valid;
      assign src_a[k] = bus.a;
      assign src_b[k] = bus.sub ? ~bus.b : bus.b;
      assign src_c[k] = bus.cin ^ bus.sub;
      assign src_s[k] = '0;
    end else begin : g_next
      assign src_v[k] = v_q[k-1];
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_s[k] = s_q[k-1];
    end

    rca_slice #(.SW(SW)) u_slice (
      .a     (src_a[k][k*SW +: SW]),
      .b     (src_b[k][k*SW +: SW]),
      .cin   (src_c[k]),
      .sum   (sl_sum[k]),
      .cout  (sl_cout[k]),
      .c_msb (sl_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]              = src_v[k];
      a_d[k]              = src_a[k];
      b_d[k]              = src_b[k];
      c_d[k]              = sl_cout[k];
      s_d[k]              = src_s[k];
      s_d[k][k*SW +: SW]  = sl_sum[k];
    end
    ovf_d = sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed vectors, random traffic against an
// arithmetic reference queue, mid-flight reset, and STAGES=1/16 latency builds.
module tb_pipelined_rca;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_rca_if #(.WIDTH(W)) ifc ();
  pipelined_rca_if #(.WIDTH(W)) ifc1 ();
  pipelined_rca_if #(.WIDTH(W)) ifc16 ();

  pipelined_rca #(.WIDTH(W), .STAGES(S))  dut   (.clk(clk), .rst(rst), .bus(ifc));
  pipelined_rca #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1));
  pipelined_rca #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));

  int   tests = 0;
  int   fails = 0;
  int   n_in  = 0;
  int   n_out = 0;
  res_t exp_q[$];

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ci = cin ? 64'sd1 : 64'sd0;
    longint u;
    longint s;
    res_t   r;
    if (sub) begin
      u      = ua - ub - ci;
      s      = sa - sb - ci;
      r.cout = (u >= 0);
    end else begin
      u      = ua + ub + ci;
      s      = sa + sb + ci;
      r.cout = (u >= (longint'(1) << W));
    end
    r.sum = u[W-1:0];
    r.ovf = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
    return r;
  endfunction

  // Monitor: scoreboard, in_ready rule, stability under stall.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;
    res_t         e;
    prev_stall = 1'b0;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        tests++;
        assert (ifc.in_ready === (~ifc.out_valid | ifc.out_ready)) else begin
          fails++;
          $error("FAIL in_ready_rule: got %b want %b", ifc.in_ready, ~ifc.out_valid | ifc.out_ready);
        end
        if (prev_stall) begin
          tests++;
          assert ({ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf} === {1'b1, prev_sum, prev_cout, prev_ovf}) else begin
            fails++;
            $error("FAIL stall_hold: got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                   ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf, prev_sum, prev_cout, prev_ovf);
          end
        end
        if (ifc.in_valid && ifc.in_ready) begin
          exp_q.push_back(ref_op(ifc.a, ifc.b, ifc.cin, ifc.sub));
          n_in++;
        end
        if (ifc.out_valid && ifc.out_ready) begin
          tests++;
          assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_beat: got sum=%h with %0d beats expected", ifc.sum, exp_q.size());
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            assert ({ifc.sum, ifc.cout, ifc.ovf} === {e.sum, e.cout, e.ovf}) else begin
              fails++;
              $error("FAIL result_beat%0d: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     n_out, ifc.sum, ifc.cout, ifc.ovf, e.sum, e.cout, e.ovf);
            end
          end
          n_out++;
        end
        prev_stall = ifc.out_valid & ~ifc.out_ready;
        prev_sum   = ifc.sum;
        prev_cout  = ifc.cout;
        prev_ovf   = ifc.ovf;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic one_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, output int lat);
    @(posedge clk);
    #1;
    ifc.a = a; ifc.b = b; ifc.cin = cin; ifc.sub = sub; ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    lat = 1;
    while (lat <= 40) begin
      @(negedge clk);
      if (ifc.out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          cyc;
    int          start;
    int          seen;
    int          lat1;
    int          lat16;
    logic [W-1:0] s1;
    logic [W-1:0] s16;
    logic        o1;
    logic        o16;
    logic        c1;
    logic        c16;
    logic [31:0] r0;
    logic [31:0] r1;

    ifc.in_valid = 0; ifc.a = '0; ifc.b = '0; ifc.cin = 0; ifc.sub = 0; ifc.out_ready = 1;
    ifc1.in_valid = 0; ifc1.a = '0; ifc1.b = '0; ifc1.cin = 0; ifc1.sub = 0; ifc1.out_ready = 1;
    ifc16.in_valid = 0; ifc16.a = '0; ifc16.b = '0; ifc16.cin = 0; ifc16.sub = 0; ifc16.out_ready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    tests++;
    assert ({ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf, ifc.in_ready} === {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) else begin
      fails++;
      $error("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b want v=0 sum=0000 c=0 o=0 rdy=1",
             ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf, ifc.in_ready);
    end

    one_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    tests++;
    assert (lat === S) else begin fails++; $error("FAIL ripple_latency: got %0d want %0d", lat, S); end
    tests++;
    assert ({ifc.sum, ifc.cout, ifc.ovf} === {16'h0000, 1'b1, 1'b0}) else begin
      fails++;
      $error("FAIL ripple_add: got sum=%h c=%b o=%b want sum=0000 c=1 o=0", ifc.sum, ifc.cout, ifc.ovf);
    end

    one_beat(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    tests++;
    assert ({ifc.sum, ifc.cout, ifc.ovf} === {16'h7FFF, 1'b1, 1'b1}) else begin
      fails++;
      $error("FAIL sub_ovf: got sum=%h c=%b o=%b want sum=7fff c=1 o=1", ifc.sum, ifc.cout, ifc.ovf);
    end

    one_beat(16'h0000, 16'h0001, 1'b0, 1'b1, lat);
    tests++;
    assert ({ifc.sum, ifc.cout, ifc.ovf} === {16'hFFFF, 1'b0, 1'b0}) else begin
      fails++;
      $error("FAIL sub_borrow: got sum=%h c=%b o=%b want sum=ffff c=0 o=0", ifc.sum, ifc.cout, ifc.ovf);
    end

    one_beat(16'h1234, 16'h0FF0, 1'b1, 1'b1, lat);
    tests++;
    assert ({ifc.sum, ifc.cout, ifc.ovf} === {16'h0243, 1'b1, 1'b0}) else begin
      fails++;
      $error("FAIL sub_cin: got sum=%h c=%b o=%b want sum=0243 c=1 o=0", ifc.sum, ifc.cout, ifc.ovf);
    end

    // Back-to-back full-rate traffic.
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      r0 = $urandom; r1 = $urandom;
      ifc.a = r0[15:0]; ifc.b = r0[31:16]; ifc.cin = r1[0]; ifc.sub = r1[1]; ifc.in_valid = 1'b1;
      @(negedge clk);
      if (i >= S) begin
        tests++;
        assert (ifc.out_valid === 1'b1) else begin
          fails++;
          $error("FAIL b2b_continuous%0d: got out_valid=%b want 1", i, ifc.out_valid);
        end
      end
    end
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin @(negedge clk); cyc++; end
    tests++;
    assert (exp_q.size() == 0) else begin fails++; $error("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end

    // Random valid/ready traffic.
    start = n_in;
    cyc   = 0;
    while ((n_in - start) < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      r0 = $urandom; r1 = $urandom;
      ifc.a = r0[15:0]; ifc.b = r0[31:16]; ifc.cin = r1[0]; ifc.sub = r1[1];
      ifc.in_valid = r1[2]; ifc.out_ready = r1[3];
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tests++;
    assert ((n_in - start) >= 1000) else begin
      fails++;
      $error("FAIL random_accepts: got %0d want 1000", n_in - start);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin @(negedge clk); cyc++; end
    tests++;
    assert (n_out === n_in) else begin fails++; $error("FAIL random_count: got %0d outputs want %0d", n_out, n_in); end

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      r0 = $urandom;
      ifc.a = r0[15:0]; ifc.b = r0[31:16]; ifc.cin = 1'b0; ifc.sub = 1'b0; ifc.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    assert ({ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf} === {1'b0, 16'h0000, 1'b0, 1'b0}) else begin
      fails++;
      $error("FAIL midreset_clear: got v=%b sum=%h c=%b o=%b want v=0 sum=0000 c=0 o=0",
             ifc.out_valid, ifc.sum, ifc.cout, ifc.ovf);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.out_valid) seen++;
    end
    tests++;
    assert (seen === 0) else begin fails++; $error("FAIL midreset_stale: got %0d beats want 0", seen); end
    one_beat(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    tests++;
    assert ({lat, ifc.sum, ifc.cout, ifc.ovf} === {S, 16'h5556, 1'b0, 1'b0}) else begin
      fails++;
      $error("FAIL post_reset_beat: got lat=%0d sum=%h c=%b o=%b want lat=%0d sum=5556 c=0 o=0",
             lat, ifc.sum, ifc.cout, ifc.ovf, S);
    end

    // STAGES=1 and STAGES=16 builds.
    @(posedge clk);
    #1;
    ifc1.a = 16'h7FFF; ifc1.b = 16'h0001; ifc1.in_valid = 1'b1;
    ifc16.a = 16'h7FFF; ifc16.b = 16'h0001; ifc16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc1.in_valid = 1'b0;
    ifc16.in_valid = 1'b0;
    lat1 = 0; lat16 = 0; s1 = '0; s16 = '0; o1 = 0; o16 = 0; c1 = 0; c16 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ifc1.out_valid && lat1 == 0) begin lat1 = n; s1 = ifc1.sum; o1 = ifc1.ovf; c1 = ifc1.cout; end
      if (ifc16.out_valid && lat16 == 0) begin lat16 = n; s16 = ifc16.sum; o16 = ifc16.ovf; c16 = ifc16.cout; end
      @(posedge clk);
    end
    tests++;
    assert ({lat1, s1, c1, o1} === {32'sd1, 16'h8000, 1'b0, 1'b1}) else begin
      fails++;
      $error("FAIL stages1: got lat=%0d sum=%h c=%b o=%b want lat=1 sum=8000 c=0 o=1", lat1, s1, c1, o1);
    end
    tests++;
    assert ({lat16, s16, c16, o16} === {32'sd16, 16'h8000, 1'b0, 1'b1}) else begin
      fails++;
      $error("FAIL stages16: got lat=%0d sum=%h c=%b o=%b want lat=16 sum=8000 c=0 o=1", lat16, s16, c16, o16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
